// File: rtl/vga_timing_meas.sv
// rtl/vga_timing_meas.sv - measures sync/porch/visible timing of one VGA axis and tracks period lock
`timescale 1ns/1ps

package vga_pkg;
  typedef struct packed {
    logic [15:0] sync_pulse;
    logic [15:0] back_porch;
    logic [15:0] visible_area;
    logic [15:0] front_porch;
  } line_t;

  typedef enum logic [1:0] {
    SYNC       = 2'd0,
    BACKPORCH  = 2'd1,
    ACTIVE     = 2'd2,
    FRONTPORCH = 2'd3
  } VGA_state_e;
endpackage

module vga_timing_meas
  import vga_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int LOCK_COUNT = 2,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_ce,
  input  logic       i_sync_in,
  input  logic       i_active_in,
  output line_t      o_meas,
  output logic       o_meas_valid,
  output logic       o_locked,
  output logic       o_err,
  output VGA_state_e o_state
);
  localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

  logic             w_s, w_a;
  logic             w_rise_s, w_fall_s, w_rise_a, w_fall_a, w_any_edge;
  logic             r_s_q, r_a_q;
  VGA_state_e       r_state, w_state_n;
  logic             r_synced, w_synced_n;
  logic [WIDTH-1:0] r_cnt, w_cnt_n;
  logic [WIDTH-1:0] r_sp, w_sp_n, r_bp, w_bp_n, r_va, w_va_n, w_fp;
  logic             w_done, w_viol, w_adv;
  line_t            r_meas, r_prev, w_line;
  logic             r_prev_vld, r_meas_valid, r_locked, r_err;
  logic [3:0]       r_match_cnt, w_match_n;

  assign w_s        = SYNC_POL ? i_sync_in : ~i_sync_in;
  assign w_a        = i_active_in;
  assign w_rise_s   = w_s & ~r_s_q;
  assign w_fall_s   = ~w_s & r_s_q;
  assign w_rise_a   = w_a & ~r_a_q;
  assign w_fall_a   = ~w_a & r_a_q;
  assign w_any_edge = w_rise_s | w_fall_s | w_rise_a | w_fall_a;

  always_comb begin
    w_state_n  = r_state;
    w_synced_n = r_synced;
    w_cnt_n    = r_cnt;
    w_sp_n     = r_sp;
    w_bp_n     = r_bp;
    w_va_n     = r_va;
    w_fp       = '0;
    w_done     = 1'b0;
    w_viol     = 1'b0;
    w_adv      = 1'b0;
    if (i_ce) begin
      if (!r_synced) begin
        if (w_rise_s) begin
          w_synced_n = 1'b1;
          w_state_n  = SYNC;
          w_cnt_n    = WIDTH'(1);
        end
      end else begin
        if (!(w_s && w_a)) begin
          case (r_state)
            SYNC: begin
              if (w_fall_s && w_rise_a) begin
                w_sp_n = r_cnt; w_bp_n = '0; w_state_n = ACTIVE; w_adv = 1'b1;
              end else if (w_fall_s && !w_a && !w_fall_a) begin
                w_sp_n = r_cnt; w_state_n = BACKPORCH; w_adv = 1'b1;
              end
            end
            BACKPORCH: begin
              if (w_rise_a && !w_rise_s && !w_fall_s) begin
                w_bp_n = r_cnt; w_state_n = ACTIVE; w_adv = 1'b1;
              end
            end
            ACTIVE: begin
              if (w_fall_a && w_rise_s) begin
                w_va_n = r_cnt; w_done = 1'b1; w_state_n = SYNC; w_adv = 1'b1;
              end else if (w_fall_a && !w_s && !w_fall_s) begin
                w_va_n = r_cnt; w_state_n = FRONTPORCH; w_adv = 1'b1;
              end
            end
            FRONTPORCH: begin
              if (w_rise_s && !w_rise_a && !w_fall_a) begin
                w_fp = r_cnt; w_done = 1'b1; w_state_n = SYNC; w_adv = 1'b1;
              end
            end
            default: ;
          endcase
        end
        // Any unexplained edge, overlap or saturated counter drops sync; cnt is held, never wrapped.
        if (w_adv) begin
          w_cnt_n = WIDTH'(1);
        end else if ((w_s && w_a) || w_any_edge || (&r_cnt)) begin
          w_viol     = 1'b1;
          w_synced_n = 1'b0;
          w_state_n  = SYNC;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
    end
  end

  assign w_line = {16'(w_sp_n), 16'(w_bp_n), 16'(w_va_n), 16'(w_fp)};

  always_comb begin
    w_match_n = 4'd0;
    if (r_prev_vld && (w_line == r_prev))
      w_match_n = (r_match_cnt >= LOCK_MAX) ? LOCK_MAX : r_match_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s_q        <= 1'b0;
      r_a_q        <= 1'b0;
      r_state      <= SYNC;
      r_synced     <= 1'b0;
      r_cnt        <= '0;
      r_sp         <= '0;
      r_bp         <= '0;
      r_va         <= '0;
      r_meas       <= '0;
      r_prev       <= '0;
      r_prev_vld   <= 1'b0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_match_cnt  <= 4'd0;
    end else begin
      if (i_ce) begin
        r_s_q <= w_s;
        r_a_q <= w_a;
      end
      r_state      <= w_state_n;
      r_synced     <= w_synced_n;
      r_cnt        <= w_cnt_n;
      r_sp         <= w_sp_n;
      r_bp         <= w_bp_n;
      r_va         <= w_va_n;
      r_meas_valid <= w_done;
      r_err        <= w_viol;
      if (w_done) begin
        r_meas      <= w_line;
        r_prev      <= w_line;
        r_prev_vld  <= 1'b1;
        r_match_cnt <= w_match_n;
        r_locked    <= (w_match_n == LOCK_MAX);
      end
      // prev is forgotten so the first period after a resync can never count as a match
      if (w_viol) begin
        r_locked    <= 1'b0;
        r_match_cnt <= 4'd0;
        r_prev_vld  <= 1'b0;
      end
    end
  end

  assign o_meas       = r_meas;
  assign o_meas_valid = r_meas_valid;
  assign o_locked     = r_locked;
  assign o_err        = r_err;
  assign o_state      = r_state;
endmodule

// File: tb/tb_vga_timing_meas.sv
// tb/tb_vga_timing_meas.sv - table-driven bench for vga_timing_meas, both sync polarities in lockstep
`timescale 1ns/1ps

module tb_vga_timing_meas;
  import vga_pkg::*;

  typedef struct {
    int          sp, bp, va, fp, dv;
    int          exp_mv;
    logic [63:0] exp_meas;
    bit          exp_lock;
  } vec_t;

  logic clk = 1'b0, rstn = 1'b0, ce = 1'b0, sync_r = 1'b0, act_r = 1'b0;
  logic sync_n;
  always #5 clk = ~clk;
  assign sync_n = ~sync_r;

  line_t      meas1, meas2;
  logic       mv1, mv2, lk1, lk2, er1, er2;
  VGA_state_e st1, st2;

  vga_timing_meas #(.WIDTH(12), .LOCK_COUNT(2), .SYNC_POL(1'b1)) u_dut_p (
    .clk(clk), .rstn(rstn), .i_ce(ce), .i_sync_in(sync_r), .i_active_in(act_r),
    .o_meas(meas1), .o_meas_valid(mv1), .o_locked(lk1), .o_err(er1), .o_state(st1));

  vga_timing_meas #(.WIDTH(12), .LOCK_COUNT(2), .SYNC_POL(1'b0)) u_dut_n (
    .clk(clk), .rstn(rstn), .i_ce(ce), .i_sync_in(sync_n), .i_active_in(act_r),
    .o_meas(meas2), .o_meas_valid(mv2), .o_locked(lk2), .o_err(er2), .o_state(st2));

  int          tests = 0, fails = 0;
  int          mv_cnt = 0, err_cnt = 0, both_cnt = 0, hold_bad = 0, diff_cnt = 0;
  logic [63:0] last_meas = '0;
  bit          last_lock = 1'b0;
  VGA_state_e  st_prev = SYNC;
  vec_t        tbl[18];

  always @(posedge clk) begin : mon
    bit ce_at, rst_at;
    ce_at  = ce;
    rst_at = rstn;
    #1;
    if (mv1) begin mv_cnt++; last_meas = meas1; last_lock = lk1; end
    if (er1) err_cnt++;
    if (mv1 && er1) both_cnt++;
    if (rst_at && !ce_at && st1 != st_prev) hold_bad++;
    st_prev = st1;
    if ({meas1, mv1, lk1, er1, st1} != {meas2, mv2, lk2, er2, st2}) diff_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ln(input int a, input int b, input int c, input int d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  function automatic vec_t mkv(input int sp, input int bp, input int va, input int fp, input int dv,
                               input int mv, input logic [63:0] m, input bit l);
    vec_t v;
    v.sp = sp; v.bp = bp; v.va = va; v.fp = fp; v.dv = dv;
    v.exp_mv = mv; v.exp_meas = m; v.exp_lock = l;
    return v;
  endfunction

  task automatic do_tick(input bit s, input bit a, input int dv);
    @(negedge clk);
    ce = 1'b1; sync_r = s; act_r = a;
    for (int k = 1; k < dv; k++) begin
      @(negedge clk);
      ce = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b0;
    end
  endtask

  task automatic drive_period(input int sp, input int bp, input int va, input int fp, input int dv);
    for (int k = 0; k < sp; k++) do_tick(1'b1, 1'b0, dv);
    for (int k = 0; k < bp; k++) do_tick(1'b0, 1'b0, dv);
    for (int k = 0; k < va; k++) do_tick(1'b0, 1'b1, dv);
    for (int k = 0; k < fp; k++) do_tick(1'b0, 1'b0, dv);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] lh, lh9, lz, lv;
    int b_mv, b_err;
    lh  = ln(96, 48, 640, 16);
    lh9 = ln(96, 48, 639, 16);
    lz  = ln(96, 0, 640, 0);
    lv  = ln(2, 33, 480, 10);
    tbl[0]  = mkv(96, 48, 640, 16, 1, 0, '0, 1'b0);
    tbl[1]  = mkv(96, 48, 640, 16, 1, 1, lh, 1'b0);
    tbl[2]  = mkv(96, 48, 640, 16, 1, 1, lh, 1'b0);
    tbl[3]  = mkv(96, 48, 640, 16, 1, 1, lh, 1'b1);
    tbl[4]  = mkv(96, 48, 639, 16, 1, 1, lh, 1'b1);
    tbl[5]  = mkv(96, 48, 640, 16, 1, 1, lh9, 1'b0);
    tbl[6]  = mkv(96, 48, 640, 16, 1, 1, lh, 1'b0);
    tbl[7]  = mkv(96, 48, 640, 16, 1, 1, lh, 1'b0);
    tbl[8]  = mkv(96, 0, 640, 0, 1, 1, lh, 1'b1);
    tbl[9]  = mkv(96, 0, 640, 0, 1, 1, lz, 1'b0);
    tbl[10] = mkv(96, 48, 640, 16, 1, 1, lz, 1'b0);
    tbl[11] = mkv(96, 48, 640, 16, 1, 1, lh, 1'b0);
    tbl[12] = mkv(96, 48, 640, 16, 1, 1, lh, 1'b0);
    tbl[13] = mkv(96, 48, 640, 16, 1, 1, lh, 1'b1);
    tbl[14] = mkv(2, 33, 480, 10, 4, 1, lh, 1'b1);
    tbl[15] = mkv(2, 33, 480, 10, 4, 1, lv, 1'b0);
    tbl[16] = mkv(2, 33, 480, 10, 4, 1, lv, 1'b0);
    tbl[17] = mkv(2, 33, 480, 10, 4, 1, lv, 1'b1);

    repeat (3) @(negedge clk);
    check("rst_meas", meas1, '0);
    check("rst_mv", 64'(mv1), 64'd0);
    check("rst_lock", 64'(lk1), 64'd0);
    check("rst_err", 64'(er1), 64'd0);
    check("rst_state", 64'(st1), 64'(SYNC));
    check("rst_state_n", 64'(st2), 64'(SYNC));
    rstn = 1'b1;
    idle(2);

    for (int i = 0; i < 18; i++) begin
      b_mv  = mv_cnt;
      b_err = err_cnt;
      drive_period(tbl[i].sp, tbl[i].bp, tbl[i].va, tbl[i].fp, tbl[i].dv);
      check($sformatf("vec%0d_mv", i), 64'(mv_cnt - b_mv), 64'(tbl[i].exp_mv));
      if (tbl[i].exp_mv != 0) begin
        check($sformatf("vec%0d_meas", i), last_meas, tbl[i].exp_meas);
        check($sformatf("vec%0d_lock", i), 64'(last_lock), 64'(tbl[i].exp_lock));
      end
      check($sformatf("vec%0d_err", i), 64'(err_cnt - b_err), 64'd0);
    end

    // active asserted inside SYNC while locked
    b_mv = mv_cnt; b_err = err_cnt;
    repeat (5) do_tick(1'b1, 1'b0, 1);
    check("ovl_pre_lock", 64'(lk1), 64'd1);
    do_tick(1'b1, 1'b1, 1);
    repeat (2) do_tick(1'b1, 1'b0, 1);
    repeat (3) do_tick(1'b0, 1'b0, 1);
    check("ovl_err", 64'(err_cnt - b_err), 64'd1);
    check("ovl_lock", 64'(lk1), 64'd0);
    check("ovl_meas", meas1, lv);
    check("ovl_state", 64'(st1), 64'(SYNC));
    check("ovl_mv", 64'(mv_cnt - b_mv), 64'd1);
    b_mv = mv_cnt; b_err = err_cnt;
    drive_period(96, 48, 640, 16, 1);
    do_tick(1'b1, 1'b0, 1);
    idle(2);
    check("resync_mv", 64'(mv_cnt - b_mv), 64'd1);
    check("resync_meas", last_meas, lh);
    check("resync_lock", 64'(last_lock), 64'd0);
    check("resync_err", 64'(err_cnt - b_err), 64'd0);

    // sync held: tick 4095 saturates the counter, tick 4096 overflows
    b_mv = mv_cnt; b_err = err_cnt;
    repeat (4094) do_tick(1'b1, 1'b0, 1);
    idle(2);
    check("ovf_edge_err", 64'(err_cnt - b_err), 64'd0);
    repeat (11) do_tick(1'b1, 1'b0, 1);
    repeat (3) do_tick(1'b0, 1'b0, 1);
    idle(2);
    check("ovf_err", 64'(err_cnt - b_err), 64'd1);
    check("ovf_meas", meas1, lh);
    check("ovf_lock", 64'(lk1), 64'd0);
    check("ovf_state", 64'(st1), 64'(SYNC));
    check("ovf_mv", 64'(mv_cnt - b_mv), 64'd0);

    // reset pulse in the middle of ACTIVE while locked
    b_mv = mv_cnt;
    repeat (3) drive_period(96, 48, 640, 16, 1);
    drive_period(96, 48, 100, 0, 1);
    check("prerst_mv", 64'(mv_cnt - b_mv), 64'd3);
    check("prerst_lock", 64'(lk1), 64'd1);
    @(negedge clk);
    rstn = 1'b0; ce = 1'b0;
    @(negedge clk);
    check("midrst_meas", meas1, '0);
    check("midrst_mv", 64'(mv1), 64'd0);
    check("midrst_lock", 64'(lk1), 64'd0);
    check("midrst_err", 64'(er1), 64'd0);
    check("midrst_state", 64'(st1), 64'(SYNC));
    check("midrst_meas_n", meas2, '0);
    check("midrst_lock_n", 64'(lk2), 64'd0);
    check("midrst_state_n", 64'(st2), 64'(SYNC));
    rstn = 1'b1;
    b_mv = mv_cnt; b_err = err_cnt;
    drive_period(0, 0, 540, 16, 1);
    repeat (3) drive_period(96, 48, 640, 16, 1);
    do_tick(1'b1, 1'b0, 1);
    idle(2);
    check("postrst_mv", 64'(mv_cnt - b_mv), 64'd3);
    check("postrst_meas", last_meas, lh);
    check("postrst_meas_n", meas2, lh);
    check("postrst_lock", 64'(lk1), 64'd1);
    check("postrst_err", 64'(err_cnt - b_err), 64'd0);

    check("err_mv_overlap", 64'(both_cnt), 64'd0);
    check("state_hold_no_ce", 64'(hold_bad), 64'd0);
    check("polarity_lockstep", 64'(diff_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
